// File: rtl/wb_port_arbiter.sv
// rtl/wb_port_arbiter.sv - register-file write-port arbiter between pipeline WB and a queued long-latency unit
//
// Purpose:
//   Shares one register-file write port between the pipeline WB stage and
//   the long-latency unit (mul/div). Pipeline writes win. LU results wait in
//   a DEPTH-entry FIFO. If the FIFO head loses STARVE_LIMIT times in a row,
//   the pipeline is stalled for one cycle so the head can drain. busy_mask
//   exposes the queued destinations so decode can interlock on them.
//
// Optional feature (macro WB_LU_BYPASS_EN):
//   When defined, an LU result offered while the port is otherwise idle
//   (NORMAL, FIFO empty, no WB write) goes straight to rf_* without a push.
//
// Ports:
//   clk, rst                   clock (rising edge), synchronous active-high reset
//   wb_valid, wb_rd, wb_data   pipeline WB write request
//   lu_valid, lu_rd, lu_data   LU result offer; accepted when lu_ready is high
//   lu_ready                   FIFO not full (combinational from occupancy)
//   pipe_stall                 registered; pipeline must hold WB and stall upstream
//   rf_we, rf_waddr, rf_wdata  registered register-file write port
//   busy_mask                  one bit per register targeted by a queued LU result

module wb_port_arbiter #(
    parameter int DEPTH        = 2,
    parameter int STARVE_LIMIT = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        wb_valid,
    input  logic [4:0]  wb_rd,
    input  logic [31:0] wb_data,
    input  logic        lu_valid,
    input  logic [4:0]  lu_rd,
    input  logic [31:0] lu_data,
    output logic        lu_ready,
    output logic        pipe_stall,
    output logic        rf_we,
    output logic [4:0]  rf_waddr,
    output logic [31:0] rf_wdata,
    output logic [31:0] busy_mask
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(STARVE_LIMIT + 1);

    typedef enum logic {
        ST_NORMAL = 1'b0,
        ST_FORCE  = 1'b1
    } state_t;

    state_t         r_state;
    state_t         w_next_state;
    logic [CW-1:0]  r_starve;
    logic [CW-1:0]  w_starve_next;

    logic [4:0]     r_mem_rd   [DEPTH];
    logic [31:0]    r_mem_data [DEPTH];
    logic [AW:0]    r_wptr;
    logic [AW:0]    r_rptr;

    logic [AW:0]    w_count;
    logic           w_empty;
    logic           w_full;
    logic           w_bypass;
    logic           w_push;
    logic           w_pop;
    logic           w_win;
    logic [4:0]     w_win_rd;
    logic [31:0]    w_win_data;
    logic [4:0]     w_head_rd;
    logic [31:0]    w_head_data;
    logic [AW-1:0]  w_idx;
    logic [31:0]    w_busy;

    // Occupancy: the extra pointer bit separates full from empty.
    assign w_count     = r_wptr - r_rptr;
    assign w_empty     = (r_wptr == r_rptr);
    assign w_full      = (r_wptr[AW] != r_rptr[AW]) &&
                         (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
    assign w_head_rd   = r_mem_rd[r_rptr[AW-1:0]];
    assign w_head_data = r_mem_data[r_rptr[AW-1:0]];

`ifdef WB_LU_BYPASS_EN
    assign w_bypass = (r_state == ST_NORMAL) && w_empty && !wb_valid && lu_valid;
`else
    assign w_bypass = 1'b0;
`endif

    // A pop in the same cycle never reopens a full FIFO; this keeps lu_ready
    // independent of the arbitration result.
    assign lu_ready   = !w_full;
    assign w_push     = lu_valid && lu_ready && !w_bypass;
    assign pipe_stall = (r_state == ST_FORCE);

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= ST_NORMAL;
            r_starve <= '0;
        end else begin
            r_state  <= w_next_state;
            r_starve <= w_starve_next;
        end
    end

    // Next state: the counter only advances while the pipeline is beating a
    // non-empty FIFO; every other case clears it.
    always_comb begin
        w_next_state  = r_state;
        w_starve_next = '0;
        case (r_state)
            ST_NORMAL: begin
                if (wb_valid && !w_empty) begin
                    if (r_starve == CW'(STARVE_LIMIT - 1)) begin
                        w_next_state = ST_FORCE;
                    end else begin
                        w_starve_next = r_starve + 1'b1;
                    end
                end
            end
            ST_FORCE: begin
                w_next_state = ST_NORMAL;
            end
            default: begin
                w_next_state = ST_NORMAL;
            end
        endcase
    end

    // Output/winner selection. In FORCE the pipeline's request is ignored;
    // it holds its write and wins the following cycle.
    always_comb begin
        w_pop      = 1'b0;
        w_win      = 1'b0;
        w_win_rd   = wb_rd;
        w_win_data = wb_data;
        if (r_state == ST_FORCE) begin
            w_pop      = !w_empty;
            w_win      = !w_empty;
            w_win_rd   = w_head_rd;
            w_win_data = w_head_data;
        end else if (wb_valid) begin
            w_win = 1'b1;
        end else if (!w_empty) begin
            w_pop      = 1'b1;
            w_win      = 1'b1;
            w_win_rd   = w_head_rd;
            w_win_data = w_head_data;
        end else if (w_bypass) begin
            w_win      = 1'b1;
            w_win_rd   = lu_rd;
            w_win_data = lu_data;
        end
    end

    // FIFO pointers
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wptr <= '0;
            r_rptr <= '0;
        end else begin
            if (w_push) begin
                r_wptr <= r_wptr + 1'b1;
            end
            if (w_pop) begin
                r_rptr <= r_rptr + 1'b1;
            end
        end
    end

    // FIFO storage; contents are only observed for entries inside [rptr, wptr).
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem_rd[r_wptr[AW-1:0]]   <= lu_rd;
            r_mem_data[r_wptr[AW-1:0]] <= lu_data;
        end
    end

    // Registered write port; a $0 winner is consumed without a write.
    always_ff @(posedge clk) begin
        if (rst) begin
            rf_we    <= 1'b0;
            rf_waddr <= '0;
            rf_wdata <= '0;
        end else begin
            rf_we <= w_win && (w_win_rd != 5'd0);
            if (w_win) begin
                rf_waddr <= w_win_rd;
                rf_wdata <= w_win_data;
            end
        end
    end

    // Destinations of all valid entries, walked from the head.
    always_comb begin
        w_busy = '0;
        w_idx  = '0;
        for (int k = 0; k < DEPTH; k++) begin
            w_idx = r_rptr[AW-1:0] + AW'(k);
            if ((AW + 1)'(k) < w_count) begin
                w_busy = w_busy | (32'd1 << r_mem_rd[w_idx]);
            end
        end
        w_busy[0] = 1'b0;
    end

    assign busy_mask = w_busy;

endmodule

// File: tb/tb_wb_port_arbiter.sv
// tb/tb_wb_port_arbiter.sv - scoreboard bench for wb_port_arbiter

module tb_wb_port_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        wb_valid;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic        lu_valid;
    logic [4:0]  lu_rd;
    logic [31:0] lu_data;
    logic        lu_ready;
    logic        pipe_stall;
    logic        rf_we;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata;
    logic [31:0] busy_mask;

    wb_port_arbiter #(.DEPTH(2), .STARVE_LIMIT(4)) dut (
        .clk        (clk),
        .rst        (rst),
        .wb_valid   (wb_valid),
        .wb_rd      (wb_rd),
        .wb_data    (wb_data),
        .lu_valid   (lu_valid),
        .lu_rd      (lu_rd),
        .lu_data    (lu_data),
        .lu_ready   (lu_ready),
        .pipe_stall (pipe_stall),
        .rf_we      (rf_we),
        .rf_waddr   (rf_waddr),
        .rf_wdata   (rf_wdata),
        .busy_mask  (busy_mask)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          cyc;
        logic [4:0]  rd;
        logic [31:0] data;
    } exp_t;

    exp_t sb_q[$];
    int   cyc     = 0;
    int   n_total = 0;
    int   n_pass  = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        n_total++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, req, cyc);
    endtask

    // Write-port monitor: every rf_we pulse must match the oldest expectation.
    always @(negedge clk) begin
        if (rf_we === 1'b1) begin
            if (sb_q.size() == 0) begin
                n_total++;
                $display("FAIL unexpected_write: got addr %0d data 0x%0h expected no write (cycle %0d)",
                         rf_waddr, rf_wdata, cyc);
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                chk("wr_addr_data", {27'd0, rf_waddr, rf_wdata}, {27'd0, e.rd, e.data});
                chk("wr_cycle", 64'(cyc), 64'(e.cyc));
            end
        end
    end

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic exp_wr(input int lat, input logic [4:0] rd, input logic [31:0] data);
        exp_t e;
        e.cyc  = cyc + lat;
        e.rd   = rd;
        e.data = data;
        sb_q.push_back(e);
    endtask

    task automatic wb(input logic [4:0] rd, input logic [31:0] data);
        wb_valid = 1'b1;
        wb_rd    = rd;
        wb_data  = data;
    endtask

    task automatic lu(input logic [4:0] rd, input logic [31:0] data);
        lu_valid = 1'b1;
        lu_rd    = rd;
        lu_data  = data;
    endtask

    task automatic idle;
        wb_valid = 1'b0;
        lu_valid = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        wb_valid = 1'b0; wb_rd = '0; wb_data = '0;
        lu_valid = 1'b0; lu_rd = '0; lu_data = '0;
        step;
        step;
        // Reset state
        chk("rst_rf_we", 64'(rf_we), 64'd0);
        chk("rst_rf_waddr", 64'(rf_waddr), 64'd0);
        chk("rst_rf_wdata", 64'(rf_wdata), 64'd0);
        chk("rst_pipe_stall", 64'(pipe_stall), 64'd0);
        chk("rst_busy_mask", 64'(busy_mask), 64'd0);
        chk("rst_lu_ready", 64'(lu_ready), 64'd1);
        rst = 1'b0;
        step;

        // Single pipeline write, one-cycle latency
        wb(5'd5, 32'h1234);
        exp_wr(1, 5'd5, 32'h1234);
        step;
        idle;
        step;
        chk("t1_we_drops", 64'(rf_we), 64'd0);

        // Single LU result through an idle port
        lu(5'd8, 32'hCAFE);
        chk("t2_lu_ready", 64'(lu_ready), 64'd1);
`ifdef WB_LU_BYPASS_EN
        exp_wr(1, 5'd8, 32'hCAFE);
`else
        exp_wr(2, 5'd8, 32'hCAFE);
`endif
        step;
        idle;
`ifdef WB_LU_BYPASS_EN
        chk("t2_busy_bypass", 64'(busy_mask), 64'd0);
`else
        chk("t2_busy_set", 64'(busy_mask), 64'h100);
`endif
        step;
        chk("t2_busy_clear", 64'(busy_mask), 64'd0);
        step;

        // Starvation: rd=3 queued behind a continuous pipeline
        wb(5'd10, 32'hA0);
        lu(5'd3, 32'h333);
        exp_wr(1, 5'd10, 32'hA0);
        step;
        lu_valid = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            chk("t3_no_stall", 64'(pipe_stall), 64'd0);
            chk("t3_busy3", 64'(busy_mask), 64'h8);
            wb(5'(10 + k), 32'hA0 + 32'(k));
            exp_wr(1, 5'(10 + k), 32'hA0 + 32'(k));
            step;
        end
        chk("t3_stall", 64'(pipe_stall), 64'd1);
        chk("t3_busy_in_force", 64'(busy_mask), 64'h8);
        wb(5'd15, 32'hA5);
        exp_wr(1, 5'd3, 32'h333);
        step;
        chk("t3_stall_released", 64'(pipe_stall), 64'd0);
        chk("t3_busy_clear", 64'(busy_mask), 64'd0);
        exp_wr(1, 5'd15, 32'hA5);
        step;
        idle;
        step;

        // FIFO full while the pipeline keeps winning
        wb(5'd20, 32'hB0); lu(5'd6, 32'h66);
        chk("t4_ready0", 64'(lu_ready), 64'd1);
        exp_wr(1, 5'd20, 32'hB0);
        step;
        wb(5'd21, 32'hB1); lu(5'd7, 32'h77);
        chk("t4_ready1", 64'(lu_ready), 64'd1);
        exp_wr(1, 5'd21, 32'hB1);
        step;
        wb(5'd22, 32'hB2); lu(5'd9, 32'h99);
        chk("t4_full_ready", 64'(lu_ready), 64'd0);
        chk("t4_busy_full", 64'(busy_mask), 64'hC0);
        exp_wr(1, 5'd22, 32'hB2);
        step;
        wb(5'd23, 32'hB3);
        chk("t4_full_ready2", 64'(lu_ready), 64'd0);
        exp_wr(1, 5'd23, 32'hB3);
        step;
        wb(5'd24, 32'hB4);
        chk("t4_no_stall_yet", 64'(pipe_stall), 64'd0);
        exp_wr(1, 5'd24, 32'hB4);
        step;
        wb(5'd25, 32'hB5);
        chk("t4_stall", 64'(pipe_stall), 64'd1);
        chk("t4_ready_during_pop", 64'(lu_ready), 64'd0);
        exp_wr(1, 5'd6, 32'h66);
        step;
        chk("t4_ready_after_pop", 64'(lu_ready), 64'd1);
        chk("t4_busy_after_pop", 64'(busy_mask), 64'h80);
        exp_wr(1, 5'd25, 32'hB5);
        step;
        idle;
        chk("t4_busy_two", 64'(busy_mask), 64'h280);
        exp_wr(1, 5'd7, 32'h77);
        step;
        chk("t4_busy_one", 64'(busy_mask), 64'h200);
        exp_wr(1, 5'd9, 32'h99);
        step;
        chk("t4_busy_empty", 64'(busy_mask), 64'd0);
        step;

        // Register $0 from both sides: consumed, never written
        wb(5'd0, 32'hFFFF_FFFF);
        lu(5'd0, 32'h5A);
        step;
        idle;
        chk("t5_wb_r0_no_we", 64'(rf_we), 64'd0);
        chk("t5_busy_r0", 64'(busy_mask), 64'd0);
        step;
        chk("t5_lu_r0_no_we", 64'(rf_we), 64'd0);
        wb(5'd12, 32'hC); lu(5'd13, 32'hD);
        exp_wr(1, 5'd12, 32'hC);
        step;
        chk("t5_fifo_emptied", 64'(lu_ready), 64'd1);
        wb(5'd14, 32'hE); lu(5'd16, 32'hF);
        exp_wr(1, 5'd14, 32'hE);
        step;
        idle;
        exp_wr(1, 5'd13, 32'hD);
        step;
        exp_wr(1, 5'd16, 32'hF);
        step;
        step;

        // Reset with two queued results
        wb(5'd1, 32'h11); lu(5'd17, 32'h1717);
        exp_wr(1, 5'd1, 32'h11);
        step;
        wb(5'd2, 32'h22); lu(5'd18, 32'h1818);
        exp_wr(1, 5'd2, 32'h22);
        step;
        idle;
        chk("t6_busy_before_rst", 64'(busy_mask), 64'h60000);
        rst = 1'b1;
        step;
        rst = 1'b0;
        chk("t6_busy", 64'(busy_mask), 64'd0);
        chk("t6_lu_ready", 64'(lu_ready), 64'd1);
        chk("t6_rf_we", 64'(rf_we), 64'd0);
        chk("t6_pipe_stall", 64'(pipe_stall), 64'd0);
        for (int k = 0; k < 6; k++) step;

        chk("sb_drained", 64'(sb_q.size()), 64'd0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
